// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: HI/LO unit op codes and iterative-unit state encoding.
// Used by the multiply/divide unit and the ALU-control decoder.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OP_DIVU  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_MULT  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } mult_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_cpu_mult_div.sv
// Iterative MIPS HI/LO unit: 32-step shift-add multiply and restoring divide on
// magnitudes, with sign fix-up in a final cycle. Also handles MTHI/MTLO/MFHI/MFLO.
module mips_cpu_mult_div
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state;
  mult_op_t    op_code;
  logic [63:0] work;
  logic [31:0] opnd;
  logic [4:0]  count;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;

  logic [32:0] add_sum;
  logic [63:0] shl;
  logic [32:0] sub_diff;
  logic [63:0] mul_next;
  logic [63:0] div_next;

  assign op_code = mult_op_t'(op);
  assign busy    = (state != IDLE);

  always_comb begin
    result = 32'd0;
    if (op_code == OP_MFHI) result = hi;
    else if (op_code == OP_MFLO) result = lo;
  end

  // Multiply: conditionally add the multiplicand into the upper half, then shift right.
  assign add_sum  = {1'b0, work[63:32]} + {1'b0, opnd};
  assign mul_next = work[0] ? {add_sum, work[31:1]} : {1'b0, work[63:1]};

  // Divide: shift left, trial-subtract the divisor; the bit shifted out keeps the compare 33 bits wide.
  assign shl      = {work[62:0], 1'b0};
  assign sub_diff = {work[63], shl[63:32]} - {1'b0, opnd};
  assign div_next = sub_diff[32] ? shl : {sub_diff[31:0], shl[31:1], 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      work   <= 64'd0;
      opnd   <= 32'd0;
      count  <= 5'd0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= 5'd0;
            case (op_code)
              OP_MULT: begin
                opnd   <= abs32(rs_data);
                work   <= {32'd0, abs32(rt_data)};
                is_div <= 1'b0;
                neg_lo <= rs_data[31] ^ rt_data[31];
                neg_hi <= 1'b0;
                state  <= ITER;
              end
              OP_MULTU: begin
                opnd   <= rs_data;
                work   <= {32'd0, rt_data};
                is_div <= 1'b0;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                state  <= ITER;
              end
              OP_DIV: begin
                // A zero divisor keeps the all-ones quotient and leaves the remainder equal to rs.
                opnd   <= abs32(rt_data);
                work   <= {32'd0, abs32(rs_data)};
                is_div <= 1'b1;
                neg_lo <= (rs_data[31] ^ rt_data[31]) && (rt_data != 32'd0);
                neg_hi <= rs_data[31];
                state  <= ITER;
              end
              OP_DIVU: begin
                opnd   <= rt_data;
                work   <= {32'd0, rs_data};
                is_div <= 1'b1;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                state  <= ITER;
              end
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              default: ;
            endcase
          end
        end
        ITER: begin
          work  <= is_div ? div_next : mul_next;
          count <= count + 5'd1;
          if (count == 5'(MD_ITERS - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= neg_hi ? (~work[63:32] + 32'd1) : work[63:32];
            lo <= neg_lo ? (~work[31:0] + 32'd1) : work[31:0];
          end else begin
            {hi, lo} <= neg_lo ? (~work + 64'd1) : work;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Bench for mips_cpu_mult_div: arithmetic reference model checked every cycle,
// plus literal expectations for the directed vectors.
module tb_mips_cpu_mult_div;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy, done;
  logic [31:0] result, hi, lo;

  int n_checks = 0;
  int n_fail = 0;

  mips_cpu_mult_div dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from MIPS arithmetic rules: {HI, LO}.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sb, q, r;
    sa = a;
    sb = b;
    case (o)
      3'b011: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      3'b001: return {32'd0, a} * {32'd0, b};
      3'b000: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'b010: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  logic        m_done;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 64'd0;
      m_done <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (start) begin
        case (op)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            m_pend <= ref_op(op, rs_data, rt_data);
            m_left <= 33;
          end
          3'b100: m_hi <= rs_data;
          3'b101: m_lo <= rs_data;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("result", result, (op == 3'b110) ? m_hi : (op == 3'b111) ? m_lo : 32'd0);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111; rs_data = 32'hDEADBEEF; rt_data = 32'h0BADF00D;
  endtask

  task automatic wait_done(input string name, output int bc);
    bit got;
    got = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
    end
    chk({name, " done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int bc;
    issue(o, a, b);
    wait_done(name, bc);
    chk({name, " busy_cycles"}, 32'(bc), 32'd33);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bc;
    #12;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // MTHI then MFHI
    @(posedge clk); #1;
    start = 1'b1; op = 3'b100; rs_data = 32'hAAAA5555;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b110;
    @(negedge clk);
    chk("mfhi result", result, 32'hAAAA5555);
    chk("mthi busy", 32'(busy), 32'd0);

    run_arith("mult -3*5", 3'b011, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_arith("multu max*max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_arith("divu 100/7", 3'b000, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    run_arith("div -7/2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_arith("div 7/-2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_arith("div min/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_arith("divu x/0", 3'b000, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_arith("div -5/0", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

    // start issued in the cycle done is high
    #1;
    start = 1'b1; op = 3'b011; rs_data = 32'd7; rt_data = 32'hFFFFFFFA;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    wait_done("back-to-back mult", bc);
    chk("back-to-back busy_cycles", 32'(bc), 32'd33);
    chk("back-to-back hi", hi, 32'hFFFFFFFF);
    chk("back-to-back lo", lo, 32'hFFFFFFD6);

    // MTLO while busy is ignored
    issue(3'b011, 32'h00010000, 32'h00010000);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'b101; rs_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    @(negedge clk);
    chk("mtlo while busy lo", lo, 32'hFFFFFFD6);
    wait_done("mult after ignored mtlo", bc);
    chk("mult 2^16*2^16 hi", hi, 32'h00000001);
    chk("mult 2^16*2^16 lo", lo, 32'h00000000);

    // MFHI with start does not disturb state
    @(posedge clk); #1;
    start = 1'b1; op = 3'b110;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mfhi start result", result, 32'h00000001);
    chk("mfhi start busy", 32'(busy), 32'd0);

    // reset in the middle of a MULT
    issue(3'b011, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("mid reset hi", hi, 32'd0);
    chk("mid reset lo", lo, 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_arith("multu 3*4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
